// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI shifter (master side) and spi_reg_ctrl (slave side).
interface spi_reg_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cs_n_sync;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    output rx_data, rx_valid, cs_n_sync,
    input  tx_data, tx_start
  );

  modport slave (
    input  rx_data, rx_valid, cs_n_sync,
    output tx_data, tx_start
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Parses [CMD][DATA] SPI frames into register-bank reads/writes.
// Optional error counter enabled by defining SPI_REG_CTRL_ERR_CNT_EN.
module spi_reg_ctrl #(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_ctrl_if.slave         spi,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];

  logic                byte_ok;
  logic                abort;
  logic [ADDR_W-1:0]   rx_addr;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [7:0]          rd_byte;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  assign abort    = spi.cs_n_sync;
  assign byte_ok  = spi.rx_valid & ~spi.cs_n_sync;
  assign rx_addr  = spi.rx_data[ADDR_W-1:0];
  assign cmd_addr = cmd_q[ADDR_W-1:0];

  // Unmatched addresses fall through to zero, which is the out-of-range read value.
  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rx_addr == ADDR_W'(i)) rd_byte = regs_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    regs_d     = regs_q;

    unique case (state_q)
      IDLE: begin
        if (byte_ok) begin
          cmd_d   = spi.rx_data;
          state_d = DATA;
          if (!spi.rx_data[7]) begin
            tx_data_d  = rd_byte;
            tx_start_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (abort) begin
          state_d = IDLE;
        end else if (spi.rx_valid) begin
          state_d = DRAIN;
          if (cmd_q[7] && addr_in_range(cmd_addr)) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = cmd_addr;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (cmd_addr == ADDR_W'(i)) regs_d[i] = spi.rx_data;
            end
          end
        end
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

  assign spi.tx_data  = tx_data_q;
  assign spi.tx_start = tx_start_q;
  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;

`ifdef SPI_REG_CTRL_ERR_CNT_EN
  logic       err_evt;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Each error source lives in a distinct state, so at most one event per cycle.
  always_comb begin
    err_evt = 1'b0;
    unique case (state_q)
      IDLE:    err_evt = byte_ok && !addr_in_range(rx_addr);
      DATA:    err_evt = abort;
      DRAIN:   err_evt = byte_ok;
      default: err_evt = 1'b0;
    endcase
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
